// File: rtl/beamscaler_reader_pkg.sv
// Shared constants, state encoding and header packing for the scaler bank reader.
package beamscaler_reader_pkg;

  localparam int          TDATA_W     = 32;
  localparam logic [3:0]  HDR_MAGIC   = 4'hB;
  localparam logic [7:0]  SUB_ADR_OFS = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    READ_REAL,
    READ_SUB,
    DRAIN
  } state_e;

  function automatic logic [31:0] make_header(input logic       bank,
                                               input logic       missed,
                                               input logic [7:0] seq,
                                               input logic [15:0] nbeams);
    return {HDR_MAGIC, bank, missed, 2'b00, seq, nbeams};
  endfunction

endpackage

// File: rtl/beamscaler_reader_if.sv
// AXI-stream style frame output channel.
interface beamscaler_reader_if;
  import beamscaler_reader_pkg::*;

  logic [TDATA_W-1:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input  m_tready);
  modport slave  (input  m_tdata, input  m_tvalid, input  m_tlast, output m_tready);
endinterface

// File: rtl/beamscaler_reader_rdfifo.sv
// Synchronous FIFO with occupancy count; the head word is presented directly and
// forced to zero while empty so the stream outputs are clean out of reset.
module beamscaler_rdfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && (cnt_q != (AW+1)'(DEPTH));
    do_pop   = pop && (cnt_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign valid = (cnt_q != '0);
  assign dout  = valid ? mem_q[rd_ptr_q] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/beamscaler_reader.sv
// Reads one scaler bank (real then subthreshold words) after each update pulse and
// streams it out as a header-prefixed frame, never issuing more reads than it can buffer.
module beamscaler_reader
  import beamscaler_reader_pkg::*;
#(
  parameter int NBEAMS     = 2,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 done_i,
  input  logic                 write_bank_i,
  output logic                 scal_rd_o,
  output logic [7:0]           scal_adr_o,
  input  logic [31:0]          scal_dat_i,
  output logic                 busy_o,
  beamscaler_reader_if.master  m_axis
);
  localparam int NWORDS = (NBEAMS + 1) / 2;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  missed_q, missed_d;
  logic [7:0]            seq_q, seq_d;
  logic [6:0]            widx_q, widx_d;
  logic [8:0]            pcnt_q, pcnt_d;
  logic                  rd_q, rd_d;
  logic [7:0]            adr_q, adr_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [CW-1:0]         infl_q, infl_d;
  logic                  busy_q, busy_d;

  logic          hdr_push, rd_push, rd_last, can_issue;
  logic          fifo_push, fifo_pop, fifo_vld;
  logic [32:0]   fifo_din, fifo_dout;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   outstanding;

  always_comb begin
    // Reads in flight are counted from the cycle they are scheduled, so buffered
    // plus pending words can never exceed the FIFO.
    outstanding = {1'b0, fifo_cnt} + {1'b0, infl_q};
    can_issue   = outstanding < (CW+1)'(FIFO_DEPTH);
    rd_push     = vld_q[RD_LATENCY-1];
    rd_last     = rd_push && (pcnt_q == 9'(2*NWORDS - 1));

    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    missed_d  = missed_q | (done_i && (state_q != IDLE));
    seq_d     = seq_q;
    widx_d    = widx_q;
    pcnt_d    = pcnt_q + 9'(rd_push);
    rd_d      = 1'b0;
    adr_d     = adr_q;
    hdr_push  = 1'b0;

    case (state_q)
      IDLE: begin
        if (done_i) begin
          state_d   = HEADER;
          rd_bank_d = ~write_bank_i;
        end
      end
      HEADER: begin
        hdr_push = 1'b1;
        missed_d = done_i;
        seq_d    = seq_q + 8'd1;
        widx_d   = '0;
        pcnt_d   = '0;
        state_d  = READ_REAL;
      end
      READ_REAL, READ_SUB: begin
        if (can_issue) begin
          rd_d  = 1'b1;
          adr_d = (state_q == READ_SUB) ? (SUB_ADR_OFS | {1'b0, widx_q}) : {1'b0, widx_q};
          if (widx_q == 7'(NWORDS - 1)) begin
            widx_d  = '0;
            state_d = (state_q == READ_SUB) ? DRAIN : READ_SUB;
          end else begin
            widx_d = widx_q + 7'd1;
          end
        end
      end
      DRAIN: begin
        if ((infl_q == '0) && (fifo_cnt == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    infl_d   = infl_q + CW'(rd_d) - CW'(rd_push);
    busy_d   = (state_d != IDLE);
    vld_d[0] = rd_q;
    for (int i = 1; i < RD_LATENCY; i++) vld_d[i] = vld_q[i-1];

    fifo_push = hdr_push | rd_push;
    fifo_din  = hdr_push ? {1'b0, make_header(rd_bank_q, missed_q, seq_q, 16'(NBEAMS))}
                         : {rd_last, scal_dat_i};
    fifo_pop  = fifo_vld & m_axis.m_tready;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      missed_q  <= 1'b0;
      seq_q     <= '0;
      widx_q    <= '0;
      pcnt_q    <= '0;
      rd_q      <= 1'b0;
      adr_q     <= '0;
      vld_q     <= '0;
      infl_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      missed_q  <= missed_d;
      seq_q     <= seq_d;
      widx_q    <= widx_d;
      pcnt_q    <= pcnt_d;
      rd_q      <= rd_d;
      adr_q     <= adr_d;
      vld_q     <= vld_d;
      infl_q    <= infl_d;
      busy_q    <= busy_d;
    end
  end

  beamscaler_rdfifo #(.DEPTH(FIFO_DEPTH), .W(33)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .valid (fifo_vld),
    .count (fifo_cnt)
  );

  assign scal_rd_o       = rd_q;
  assign scal_adr_o      = adr_q;
  assign busy_o          = busy_q;
  assign m_axis.m_tvalid = fifo_vld;
  assign m_axis.m_tdata  = fifo_dout[31:0];
  assign m_axis.m_tlast  = fifo_dout[32];

endmodule

// File: tb/tb_beamscaler_reader.sv
// Directed bench: a 2-beam and an 11-beam reader, each fed by a 2-clock RAM model.
module tb_beamscaler_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        done2, wb2, rd2, busy2;
  logic [7:0]  adr2;
  logic [31:0] dat2, p2;
  logic        done11, wb11, rd11, busy11;
  logic [7:0]  adr11;
  logic [31:0] dat11, p11;

  beamscaler_reader_if ax2();
  beamscaler_reader_if ax11();

  beamscaler_reader #(.NBEAMS(2), .RD_LATENCY(2), .FIFO_DEPTH(4)) u2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .done_i(done2), .write_bank_i(wb2),
    .scal_rd_o(rd2), .scal_adr_o(adr2), .scal_dat_i(dat2), .busy_o(busy2), .m_axis(ax2));

  beamscaler_reader #(.NBEAMS(11), .RD_LATENCY(2), .FIFO_DEPTH(4)) u11 (
    .wb_clk_i(clk), .wb_rst_i(rst), .done_i(done11), .write_bank_i(wb11),
    .scal_rd_o(rd11), .scal_adr_o(adr11), .scal_dat_i(dat11), .busy_o(busy11), .m_axis(ax11));

  function automatic logic [31:0] ram_word(input logic [7:0] a);
    return {4'h0, 4'hA, a, 4'h0, 4'h5, a};
  endfunction

  // RAM models: data is only present in the single cycle two clocks after the read.
  always @(posedge clk) begin
    p2    <= rd2 ? ram_word(adr2) : 32'h0;
    dat2  <= p2;
    p11   <= rd11 ? ram_word(adr11) : 32'h0;
    dat11 <= p11;
  end

  logic [32:0] q2[$];
  logic [32:0] q11[$];
  logic [7:0]  a2[$];
  int iss11 = 0, accd11 = 0, maxout11 = 0;

  always @(negedge clk) begin
    if (rst) begin
      iss11 = 0; accd11 = 0; maxout11 = 0;
    end else begin
      if (rd2) a2.push_back(adr2);
      if (ax2.m_tvalid && ax2.m_tready) q2.push_back({ax2.m_tlast, ax2.m_tdata});
      if (rd11) iss11++;
      if (ax11.m_tvalid && ax11.m_tready) begin
        q11.push_back({ax11.m_tlast, ax11.m_tdata});
        if (ax11.m_tdata[31:28] != 4'hB) accd11++;
      end
      if (iss11 - accd11 > maxout11) maxout11 = iss11 - accd11;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] g2(input int i);
    return (i < q2.size()) ? q2[i] : '1;
  endfunction
  function automatic logic [32:0] g11(input int i);
    return (i < q11.size()) ? q11[i] : '1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start2();
    done2 = 1'b1; step(); done2 = 1'b0;
  endtask
  task automatic start11();
    done11 = 1'b1; step(); done11 = 1'b0;
  endtask

  task automatic wait_idle2();
    for (int i = 0; i < 200; i++) begin
      if (!busy2) break;
      step();
    end
    chk("idle2_timeout", busy2, 0);
  endtask
  task automatic wait_idle11();
    for (int i = 0; i < 400; i++) begin
      if (!busy11) break;
      step();
    end
    chk("idle11_timeout", busy11, 0);
  endtask

  task automatic check_frame11(input string tag, input int base, input logic [31:0] hdr);
    logic [32:0] exp;
    chk({tag, "_count"}, q11.size() - base, 13);
    for (int i = 0; i < 13; i++) begin
      if (i == 0)     exp = {1'b0, hdr};
      else if (i < 7) exp = {1'b0, ram_word(8'(i - 1))};
      else            exp = {(i == 12), ram_word(8'h80 + 8'(i - 7))};
      chk($sformatf("%s_w%0d", tag, i), g11(base + i), exp);
    end
  endtask

  initial begin
    int base2, base11, d_base;
    bit seen;
    rst = 1'b1; done2 = 1'b0; wb2 = 1'b0; done11 = 1'b0; wb11 = 1'b1;
    ax2.m_tready = 1'b1; ax11.m_tready = 1'b1;
    repeat (3) step();
    chk("rst_tvalid", ax2.m_tvalid, 0);
    chk("rst_tlast",  ax2.m_tlast, 0);
    chk("rst_tdata",  ax2.m_tdata, 0);
    chk("rst_rd",     rd2, 0);
    chk("rst_adr",    adr2, 0);
    chk("rst_busy",   busy2, 0);
    rst = 1'b0;
    step();

    // Basic 2-beam frame
    start2();
    chk("a_busy_high", busy2, 1);
    wait_idle2();
    chk("a_count", q2.size(), 3);
    chk("a_hdr",   g2(0), {1'b0, 32'hB800_0002});
    chk("a_real",  g2(1), {1'b0, ram_word(8'h00)});
    chk("a_sub",   g2(2), {1'b1, ram_word(8'h80)});
    chk("a_nadr",  a2.size(), 2);
    chk("a_adr0",  (a2.size() > 0) ? a2[0] : 8'hFF, 8'h00);
    chk("a_adr1",  (a2.size() > 1) ? a2[1] : 8'hFF, 8'h80);

    // Sequence counter wrap over back-to-back frames
    base2 = 3;
    for (int k = 1; k <= 256; k++) begin
      start2();
      wait_idle2();
      chk($sformatf("seq_hdr%0d", k), g2(base2), {1'b0, 8'hB8, 8'(k), 16'h0002});
      base2 += 3;
    end

    // 11 beams with tready toggling every cycle
    base11 = 0;
    ax11.m_tready = 1'b0;
    start11();
    for (int i = 0; i < 400 && q11.size() < base11 + 13; i++) begin
      ax11.m_tready = ~ax11.m_tready;
      step();
    end
    ax11.m_tready = 1'b1;
    wait_idle11();
    check_frame11("tog", base11, 32'hB000_000B);
    base11 += 13;

    // done during READ_SUB is dropped and flagged in the next header
    start11();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rd11 && adr11[7]) begin seen = 1'b1; break; end
      step();
    end
    chk("b_saw_sub", seen, 1);
    start11();
    wait_idle11();
    repeat (20) step();
    chk("b_no_second", busy11, 0);
    check_frame11("b0", base11, 32'hB001_000B);
    base11 += 13;
    start11(); wait_idle11();
    check_frame11("b1", base11, 32'hB402_000B);
    base11 += 13;
    start11(); wait_idle11();
    check_frame11("b2", base11, 32'hB003_000B);
    base11 += 13;

    // Long stall mid-frame
    ax11.m_tready = 1'b0;
    d_base = iss11;
    start11();
    repeat (100) step();
    chk("d_issued",    iss11 - d_base, 3);
    chk("d_hold_vld",  ax11.m_tvalid, 1);
    chk("d_hold_data", ax11.m_tdata, 32'hB004_000B);
    chk("d_hold_last", ax11.m_tlast, 0);
    ax11.m_tready = 1'b1;
    wait_idle11();
    check_frame11("d", base11, 32'hB004_000B);
    chk("max_outstanding_ok", (maxout11 <= 4), 1);

    // Reset in the middle of READ_REAL
    ax11.m_tready = 1'b0;
    start11();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rd11 && !adr11[7]) begin seen = 1'b1; break; end
      step();
    end
    chk("e_saw_real", seen, 1);
    rst = 1'b1;
    step();
    chk("e_tvalid", ax11.m_tvalid, 0);
    chk("e_busy",   busy11, 0);
    chk("e_rd",     rd11, 0);
    rst = 1'b0;
    base11 = q11.size();
    ax11.m_tready = 1'b1;
    step();
    start11();
    wait_idle11();
    check_frame11("e", base11, 32'hB000_000B);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
